// File: rtl/magic_fetch_buffer.sv
// Instruction fetch buffer between the imem response path and decode.
// It holds {pc, instr} pairs in FIFO order, raises stall when only one
// slot remains free, and records a sticky overflow if a response still
// arrives while the buffer is full. A flush empties the buffer in one edge.
module magic_fetch_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [31:0]                pc,
  input  logic                       instr_v,
  input  logic                       imem_resp,
  input  logic [31:0]                imem_rdata,
  output logic [31:0]                imem_addr,
  output logic [3:0]                 imem_rmask,
  output logic                       stall,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [31:0]                deq_pc,
  output logic [31:0]                deq_instr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] STALL_AT = CW'(DEPTH - 1);

  // Pointers carry a wrap bit above the index so full and empty differ.
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [CW-1:0] cnt;
  logic          ovf;
  // Low until the first edge after reset release; blocks enqueue on that edge.
  logic          armed;

  logic [31:0]   mem_pc    [DEPTH];
  logic [31:0]   mem_instr [DEPTH];

  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          full;
  logic          enq;
  logic          deq;
  logic          enq_ok;
  logic          enq_drop;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];
  assign full   = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);

  assign deq_valid = (cnt != '0);
  assign enq       = imem_resp & instr_v & ~flush;
  assign deq       = deq_valid & deq_ready & ~flush;

  // A full buffer still accepts when the head leaves on the same edge,
  // since the write lands in the slot being vacated.
  assign enq_ok   = enq & armed & (~full | deq);
  assign enq_drop = enq & armed & full & ~deq;

  assign imem_addr  = {pc[31:2], 2'b00};
  assign stall      = (cnt >= STALL_AT);
  assign imem_rmask = (rst && !stall) ? 4'hF : 4'h0;

  // Head is gated so that an empty or resetting buffer presents zeros.
  assign deq_pc    = deq_valid ? mem_pc[rd_idx]    : 32'h0;
  assign deq_instr = deq_valid ? mem_instr[rd_idx] : 32'h0;
  assign count     = cnt;
  assign overflow  = ovf;

  // Control state: pointers, occupancy, overflow flag and start-up arming.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      armed  <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (enq_drop) begin
        ovf <= 1'b1;
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (enq_ok) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (deq) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({enq_ok, deq})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  // Entry storage: data only, written at the tail on an accepted enqueue.
  always_ff @(posedge clk) begin
    if (enq_ok) begin
      mem_pc[wr_idx]    <= pc;
      mem_instr[wr_idx] <= imem_rdata;
    end
  end

endmodule
